seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Parametrised multiplexed seven-segment scan engine; successor to the fixed 8-digit text driver.
//  Consumes raw per-digit segment frames from upstream formatters (FSM/timer/matrix display logic) via valid/ready.
//  Double-buffers frames and commits only at frame boundaries (no tearing).
//  Adds anti-ghost blanking, per-digit enable and blink, and optional PWM dimming.
// PARAMETERS
//  NUM_DIGITS      8      digits scanned (2..16)
//  SCAN_DIV        65536  clocks per digit slot (>= GHOST_CYC+2)
//  GHOST_CYC       16     blank clocks at start of each slot (anodes off)
//  BLINK_DIV_LOG2  25     blink period = 2^BLINK_DIV_LOG2 clocks, 50% duty
//  SEG_ACTIVE_LOW  1      1: seg_out driven low = segment lit
//  AN_ACTIVE_LOW   1      1: seg_an driven low = digit selected
// PORTS
//  clk          in   1             system clock
//  rst          in   1             synchronous reset, active-high
//  frame_data   in   8*NUM_DIGITS  digit i = [8*i+:8]; {dp,g,f,e,d,c,b,a}; 1 = lit (internal polarity)
//  frame_valid  in   1             frame offered
//  frame_ready  out  1             frame can be accepted
//  digit_en     in   NUM_DIGITS    0 = digit forced dark (sampled live)
//  blink_mask   in   NUM_DIGITS    1 = digit dark during blink off-phase (sampled live)
//  brightness   in   4             only with SEG_DIMMING_EN; 0 = dimmest, 15 = full
//  seg_out      out  8             segment drive, polarity per SEG_ACTIVE_LOW
//  seg_an       out  NUM_DIGITS    anode/cathode select, polarity per AN_ACTIVE_LOW
//  frame_sync   out  1             1-cycle pulse at frame boundary
// BEHAVIOUR
//  Reset (rst=1 at posedge): slot_cnt=0, scan_idx=0, blink_cnt=0, pending=0, active frame=all 0.
//    Outputs: seg_out all-off, seg_an all-off, frame_ready=1, frame_sync=0.
//  Reset mid-operation discards any pending frame.
//  Handshake:
//    frame_ready = !pending.
//    valid&&ready -> frame_data captured into shadow, pending=1; valid held without ready is ignored.
//  Scan:
//    slot_cnt counts 0..SCAN_DIV-1.
//    At SCAN_DIV-1, scan_idx increments, wrapping NUM_DIGITS-1 -> 0.
//  Frame boundary (slot_cnt==SCAN_DIV-1 && scan_idx==NUM_DIGITS-1):
//    If pending, shadow->active and pending clears; frame_sync=1 next cycle.
//    An accept on the boundary cycle goes to shadow and commits at the following boundary.
//  Digit lit when all hold:
//    slot_cnt >= GHOST_CYC; digit_en[scan_idx]=1; !(blink_mask[scan_idx] && blink_cnt[MSB]==0).
//  When lit: seg_an selects scan_idx only and seg_out = active[scan_idx] (polarity applied).
//  Otherwise seg_an and seg_out are all-off.
//  Outputs are registered: 1-cycle latency from counter state to pins.
//  Anode and segment values always change in the same cycle.
//  blink_cnt is free-running, width BLINK_DIV_LOG2, wraps naturally; not reset by frame commits.
// CONFIGURATION
//  SEG_DIMMING_EN defined:
//    brightness port present; free-running 4-bit pwm_cnt (+1 per clk, reset 0).
//    Additional lit condition: pwm_cnt <= brightness.
//    Duty = (brightness+1)/16; 15 = always on.
//  SEG_DIMMING_EN undefined: no brightness port, no pwm_cnt; full duty.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=8, GHOST_CYC=2, BLINK_DIV_LOG2=6, active-low)
//  1. rst=1 for 3 clk -> seg_an=4'hF, seg_out=8'hFF, frame_ready=1, frame_sync=0; hold 40 clk, still dark.
//  2. Load + scan: offer {4F,5B,06,3F} (digit0=3F).
//     -> frame_ready drops next clk; after frame_sync, digit0 slot shows seg_an=4'b1110 and seg_out=8'hC0.
//     -> This holds for 6 of 8 clk, slots 0-1 dark; digit3 shows 8'hB0.
//  3. Back-pressure: second frame offered while pending -> ignored until frame_sync.
//     -> frame_ready=1 the cycle after commit; second frame displays one frame later; no mixed digits.
//  4. Mask + blink: digit_en=4'b1011 -> digit2 slot always dark.
//     -> blink_mask=4'b0001: digit0 dark for 32 clk, lit for 32 clk, repeating.
//  5. Reset mid-frame with frame pending -> outputs dark next clk, frame_ready=1, previous frame not shown.
//  6. SEG_DIMMING_EN, brightness=0 -> each lit slot lights only cycles where pwm_cnt==0.
//     -> brightness=15 matches the undefined-macro waveform exactly.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// Frame handshake bundle between an upstream display formatter and the scan engine.
//   frame_data  : NUM_DIGITS packed segment bytes, digit i = [8*i +: 8], {dp,g,f,e,d,c,b,a}, 1 = lit
//   frame_valid : producer offers frame_data
//   frame_ready : consumer can take a frame this cycle
// master = formatter side, slave = scan engine side.
interface seg_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic [8*NUM_DIGITS-1:0] frame_data;
  logic                    frame_valid;
  logic                    frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scan engine.
// Takes whole segment frames over a valid/ready handshake into a shadow buffer and
// swaps them into the displayed buffer only at frame boundaries, so digits never tear.
// Each digit slot starts with a blanking window (anti-ghost); digits may be masked or
// blinked individually. Optional macro SEG_DIMMING_EN adds a 4-bit PWM brightness input.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   frame        : seg_scan_mux_if slave (frame_data / frame_valid / frame_ready)
//   digit_en     : per-digit enable, 0 = forced dark
//   blink_mask   : per-digit blink, dark while the blink counter MSB is 0
//   brightness   : (SEG_DIMMING_EN only) 0 = dimmest, 15 = full
//   seg_out      : segment drive, polarity per SEG_ACTIVE_LOW
//   seg_an       : digit select, polarity per AN_ACTIVE_LOW
//   frame_sync   : one-cycle pulse after a frame boundary that committed a new frame
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned SCAN_DIV       = 65536,
  parameter int unsigned GHOST_CYC      = 16,
  parameter int unsigned BLINK_DIV_LOG2 = 25,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_mux_if.slave         frame,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] blink_mask,
`ifdef SEG_DIMMING_EN
  input  logic [3:0]            brightness,
`endif
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] seg_an,
  output logic                  frame_sync
);

  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned BLK_W  = BLINK_DIV_LOG2;

  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [SLOT_W-1:0]               slot_cnt;
  logic [IDX_W-1:0]                scan_idx;
  logic [BLK_W-1:0]                blink_cnt;
  logic                            pending;
  logic [NUM_DIGITS-1:0][7:0]      shadow;
  logic [NUM_DIGITS-1:0][7:0]      active;
`ifdef SEG_DIMMING_EN
  logic [3:0]                      pwm_cnt;
`endif

  logic                  slot_last_c;
  logic                  boundary_c;
  logic                  lit_c;
  logic [NUM_DIGITS-1:0] sel_c;

  // Slot/frame boundary decode and lit decision for the digit currently scanned.
  always_comb begin
    slot_last_c = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    boundary_c  = slot_last_c && (scan_idx == IDX_W'(NUM_DIGITS - 1));
    lit_c       = (slot_cnt >= SLOT_W'(GHOST_CYC)) && digit_en[scan_idx] &&
                  !(blink_mask[scan_idx] && !blink_cnt[BLK_W-1]);
`ifdef SEG_DIMMING_EN
    lit_c       = lit_c && (pwm_cnt <= brightness);
`endif
    sel_c       = NUM_DIGITS'(1) << scan_idx;
  end

  // Scan counters, double buffer and registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      scan_idx   <= '0;
      blink_cnt  <= '0;
      pending    <= 1'b0;
      shadow     <= '0;
      active     <= '0;
      seg_out    <= SEG_OFF;
      seg_an     <= AN_OFF;
      frame_sync <= 1'b0;
`ifdef SEG_DIMMING_EN
      pwm_cnt    <= '0;
`endif
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
`ifdef SEG_DIMMING_EN
      pwm_cnt   <= pwm_cnt + 4'd1;
`endif
      if (slot_last_c) begin
        slot_cnt <= '0;
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end

      frame_sync <= boundary_c && pending;
      if (boundary_c && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      // Accept only when nothing is pending; a boundary-cycle accept waits a full frame.
      if (frame.frame_valid && !pending) begin
        shadow  <= frame.frame_data;
        pending <= 1'b1;
      end

      // Anode and segments switch together from the same lit decision.
      seg_an  <= lit_c ? (sel_c ^ AN_OFF) : AN_OFF;
      seg_out <= lit_c ? (active[scan_idx] ^ SEG_OFF) : SEG_OFF;
    end
  end

  assign frame.frame_ready = !pending;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with 4 digits, 8-clock slots, 2 blank clocks,
// 64-clock blink period, active-low pins. Frames are captured from the frame_sync
// anchor and compared cycle by cycle against hand-derived digit/slot expectations.
module tb_seg_scan_mux;

  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] digit_en;
  logic [ND-1:0] blink_mask;
`ifdef SEG_DIMMING_EN
  logic [3:0]    brightness;
`endif
  logic [7:0]    seg_out;
  logic [ND-1:0] seg_an;
  logic          frame_sync;

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS(ND), .SCAN_DIV(8), .GHOST_CYC(2), .BLINK_DIV_LOG2(6),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame      (bus),
    .digit_en   (digit_en),
    .blink_mask (blink_mask),
`ifdef SEG_DIMMING_EN
    .brightness (brightness),
`endif
    .seg_out    (seg_out),
    .seg_an     (seg_an),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;   // clock edges since reset release

  localparam logic [31:0] FRAME_A = 32'h4F5B063F;
  localparam logic [31:0] FRAME_B = 32'h664F5B06;
  localparam logic [31:0] FRAME_C = 32'hFFFFFFFF;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait for a frame_sync pulse; also counts cycles where ready was seen high before it.
  task automatic wait_sync(input string tag, input int max_cyc, output int ready_hi);
    int n;
    n = 0;
    ready_hi = 0;
    while (n < max_cyc && frame_sync !== 1'b1) begin
      tick();
      n++;
      if (frame_sync !== 1'b1 && bus.frame_ready === 1'b1) ready_hi++;
    end
    check_val({tag, "_sync_seen"}, 32'(frame_sync), 32'd1);
  endtask

  // Capture one 32-clock frame right after a frame_sync sample and compare each cycle.
  task automatic capture_frame(input string tag, input logic [31:0] frm,
                               input logic [3:0] en, input logic [3:0] bm,
                               input logic [3:0] bright);
    int slot, d, cnt;
    bit lit;
    logic [7:0] seg_i, seg_e;
    logic [3:0] an_e;
    for (int k = 0; k < 32; k++) begin
      tick();
      bus.frame_valid = 1'b0;
      cnt  = cyc - 1;
      slot = k % 8;
      d    = k / 8;
      lit  = (slot >= 2) && en[d] && !(bm[d] && ((cnt % 64) < 32)) &&
             ((cnt % 16) <= int'(bright));
      seg_i = frm[8*d +: 8];
      seg_e = lit ? ~seg_i : 8'hFF;
      an_e  = lit ? ~(4'b0001 << d) : 4'hF;
      check_val($sformatf("%s_d%0d_s%0d", tag, d, slot),
                {20'd0, seg_an, seg_out}, {20'd0, an_e, seg_e});
    end
  endtask

  int ready_hi;
  int bad_cnt;
  int sync_cnt;

  initial begin
    rst              = 1'b1;
    digit_en         = 4'hF;
    blink_mask       = 4'h0;
    bus.frame_valid  = 1'b0;
    bus.frame_data   = '0;
`ifdef SEG_DIMMING_EN
    brightness       = 4'd15;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_an",    32'(seg_an), 32'hF);
    check_val("rst_seg",   32'(seg_out), 32'hFF);
    check_val("rst_ready", 32'(bus.frame_ready), 32'd1);
    check_val("rst_sync",  32'(frame_sync), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Idle with empty active frame: segments stay off, no sync.
    bad_cnt  = 0;
    sync_cnt = 0;
    repeat (40) begin
      tick();
      if (seg_out !== 8'hFF) bad_cnt++;
      if (frame_sync !== 1'b0) sync_cnt++;
    end
    check_val("idle_dark", 32'(bad_cnt), 32'd0);
    check_val("idle_nosync", 32'(sync_cnt), 32'd0);

    // Load frame A, then hold frame B under back-pressure.
    bus.frame_data  = FRAME_A;
    bus.frame_valid = 1'b1;
    tick();
    check_val("ready_drop", 32'(bus.frame_ready), 32'd0);
    bus.frame_data  = FRAME_B;
    wait_sync("a", 100, ready_hi);
    check_val("bp_ready_low", 32'(ready_hi), 32'd0);
    check_val("ready_after_commit", 32'(bus.frame_ready), 32'd1);

    // Frame A displayed untouched while B (accepted on first capture cycle) waits.
    capture_frame("scan_a", FRAME_A, 4'hF, 4'h0, 4'd15);
    check_val("sync_b", 32'(frame_sync), 32'd1);
    capture_frame("scan_b", FRAME_B, 4'hF, 4'h0, 4'd15);

    // Digit 2 masked off.
    digit_en = 4'b1011;
    capture_frame("mask", FRAME_B, 4'b1011, 4'h0, 4'd15);
    digit_en = 4'hF;

    // Digit 0 blinks: alternates dark/lit every 32 clocks.
    blink_mask = 4'b0001;
    capture_frame("blink0", FRAME_B, 4'hF, 4'b0001, 4'd15);
    capture_frame("blink1", FRAME_B, 4'hF, 4'b0001, 4'd15);
    blink_mask = 4'b0000;

`ifdef SEG_DIMMING_EN
    brightness = 4'd0;
    capture_frame("dim0", FRAME_B, 4'hF, 4'h0, 4'd0);
    brightness = 4'd5;
    capture_frame("dim5", FRAME_B, 4'hF, 4'h0, 4'd5);
    brightness = 4'd15;
    capture_frame("dim15", FRAME_B, 4'hF, 4'h0, 4'd15);
`endif

    // Reset mid-frame with frame C pending.
    bus.frame_data  = FRAME_C;
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    check_val("c_pending", 32'(bus.frame_ready), 32'd0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_val("mid_rst_an",    32'(seg_an), 32'hF);
    check_val("mid_rst_seg",   32'(seg_out), 32'hFF);
    check_val("mid_rst_ready", 32'(bus.frame_ready), 32'd1);
    check_val("mid_rst_sync",  32'(frame_sync), 32'd0);
    rst = 1'b0;
    cyc = 0;
    bad_cnt  = 0;
    sync_cnt = 0;
    repeat (64) begin
      tick();
      if (seg_out !== 8'hFF) bad_cnt++;
      if (frame_sync !== 1'b0) sync_cnt++;
    end
    check_val("post_rst_dark", 32'(bad_cnt), 32'd0);
    check_val("post_rst_nosync", 32'(sync_cnt), 32'd0);
    check_val("post_rst_ready", 32'(bus.frame_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
